// File: rtl/div_wb_unit_if.sv
// Bundle of operand request, status, result and register-bank write-back
// signals for div_wb_unit. The sign_op signal exists only when DIV_SIGNED_EN
// is defined.
interface div_wb_unit_if #(
   parameter int WIDTH = 32,
   parameter int AW    = 4
) ();
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic [AW-1:0]    rd_q;
   logic [AW-1:0]    rd_r;
`ifdef DIV_SIGNED_EN
   logic             sign_op;
`endif
   logic             busy;
   logic             done;
   logic             div_zero;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic [AW-1:0]    wb_rd;
   logic [WIDTH-1:0] wb_data;
   logic             wb_write;
   logic             wb_enable;

   // Requester side: issues operands, observes status and the write port.
   modport master (
`ifdef DIV_SIGNED_EN
      output sign_op,
`endif
      output start, dividend, divisor, rd_q, rd_r,
      input  busy, done, div_zero, quotient, remainder,
      input  wb_rd, wb_data, wb_write, wb_enable
   );

   // Divider side.
   modport slave (
`ifdef DIV_SIGNED_EN
      input  sign_op,
`endif
      input  start, dividend, divisor, rd_q, rd_r,
      output busy, done, div_zero, quotient, remainder,
      output wb_rd, wb_data, wb_write, wb_enable
   );
endinterface

// File: rtl/div_wb_unit.sv
// div_wb_unit: restoring multicycle divider (one quotient bit per clock)
// that writes quotient then remainder back through the register bank port.
// Optional macro DIV_SIGNED_EN adds two's complement division via sign_op.
module div_wb_unit #(
   parameter int WIDTH = 32,
   parameter int AW    = 4
) (
   input logic         clk,
   input logic         reset_all_n,
   div_wb_unit_if.slave bus
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

   typedef enum logic [2:0] {S_IDLE, S_CALC, S_WB_Q, S_WB_R, S_DONE} state_t;

   state_t           r_state, w_next;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_dvs, r_quo, r_rem;
   logic [AW-1:0]    r_rd_q, r_rd_r;
   logic             r_busy, r_done, r_div_zero, r_wb_write, r_wb_enable;
   logic [WIDTH-1:0] r_quotient, r_remainder, r_wb_data;
   logic [AW-1:0]    r_wb_rd;

   logic             w_dz;
   logic [WIDTH:0]   w_rem_sh, w_trial;
   logic [WIDTH-1:0] w_dvd_mag, w_dvs_mag, w_q_fix, w_r_fix;

   assign w_dz     = (bus.divisor == '0);
   // Partial remainder is always below the divisor, so the shifted value
   // plus the sign of the trial subtraction fit in WIDTH+1 bits.
   assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};
   assign w_trial  = w_rem_sh - {1'b0, r_dvs};

`ifdef DIV_SIGNED_EN
   logic r_neg_q, r_neg_r;
   logic w_neg_a, w_neg_b;

   assign w_neg_a   = bus.sign_op & bus.dividend[WIDTH-1];
   assign w_neg_b   = bus.sign_op & bus.divisor[WIDTH-1];
   assign w_dvd_mag = w_neg_a ? -bus.dividend : bus.dividend;
   assign w_dvs_mag = w_neg_b ? -bus.divisor  : bus.divisor;
   // Divide-by-zero results are passed through without sign correction.
   assign w_q_fix   = (r_neg_q && !r_div_zero) ? -r_quo : r_quo;
   assign w_r_fix   = (r_neg_r && !r_div_zero) ? -r_rem : r_rem;

   // Sign of each result, captured with the operands.
   always_ff @(posedge clk or negedge reset_all_n) begin
      if (!reset_all_n) begin
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
      end else if (r_state == S_IDLE && bus.start) begin
         r_neg_q <= w_neg_a ^ w_neg_b;
         r_neg_r <= w_neg_a;
      end
   end
`else
   assign w_dvd_mag = bus.dividend;
   assign w_dvs_mag = bus.divisor;
   assign w_q_fix   = r_quo;
   assign w_r_fix   = r_rem;
`endif

   // State register.
   always_ff @(posedge clk or negedge reset_all_n) begin
      if (!reset_all_n) r_state <= S_IDLE;
      else              r_state <= w_next;
   end

   // Next-state decode; start is only honoured in IDLE.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (bus.start) w_next = w_dz ? S_WB_Q : S_CALC;
         S_CALC:  if (r_cnt == '0) w_next = S_WB_Q;
         S_WB_Q:  w_next = S_WB_R;
         S_WB_R:  w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Operand capture, restoring iteration and registered outputs; strobes
   // and done trail the state by one clock so every output is a flop.
   always_ff @(posedge clk or negedge reset_all_n) begin
      if (!reset_all_n) begin
         r_cnt       <= '0;
         r_dvs       <= '0;
         r_quo       <= '0;
         r_rem       <= '0;
         r_rd_q      <= '0;
         r_rd_r      <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_div_zero  <= 1'b0;
         r_wb_write  <= 1'b0;
         r_wb_enable <= 1'b0;
         r_quotient  <= '0;
         r_remainder <= '0;
         r_wb_data   <= '0;
         r_wb_rd     <= '0;
      end else begin
         r_busy      <= (w_next != S_IDLE);
         r_done      <= (r_state == S_DONE);
         r_wb_write  <= (r_state == S_WB_Q) || (r_state == S_WB_R);
         r_wb_enable <= (r_state == S_WB_Q) || (r_state == S_WB_R);
         case (r_state)
            S_IDLE: if (bus.start) begin
               r_rd_q     <= bus.rd_q;
               r_rd_r     <= bus.rd_r;
               r_dvs      <= w_dvs_mag;
               r_div_zero <= w_dz;
               r_cnt      <= CNT_MAX;
               if (w_dz) begin
                  r_quo <= '1;
                  r_rem <= bus.dividend;
               end else begin
                  r_quo <= w_dvd_mag;
                  r_rem <= '0;
               end
            end
            S_CALC: begin
               r_rem <= w_trial[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_trial[WIDTH-1:0];
               r_quo <= {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};
               r_cnt <= r_cnt - 1'b1;
            end
            S_WB_Q: begin
               r_quotient  <= w_q_fix;
               r_remainder <= w_r_fix;
               r_wb_rd     <= r_rd_q;
               r_wb_data   <= w_q_fix;
            end
            S_WB_R: begin
               r_wb_rd   <= r_rd_r;
               r_wb_data <= r_remainder;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.div_zero  = r_div_zero;
   assign bus.quotient  = r_quotient;
   assign bus.remainder = r_remainder;
   assign bus.wb_rd     = r_wb_rd;
   assign bus.wb_data   = r_wb_data;
   assign bus.wb_write  = r_wb_write;
   assign bus.wb_enable = r_wb_enable;
endmodule

// File: tb/tb_div_wb_unit.sv
// Directed bench for div_wb_unit with a register-bank model fed by the
// write port. Build with DIV_SIGNED_EN to add the signed vectors.
module tb_div_wb_unit;
   logic clk = 1'b0;
   logic reset_all_n = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   en_bad = 0;
   int   lat;

   logic [31:0] bank [16];
   logic [3:0]  wr_rd[$];
   logic [31:0] wr_data[$];
   int          wr_cyc[$];

   div_wb_unit_if #(.WIDTH(32), .AW(4)) bus ();

   div_wb_unit #(.WIDTH(32), .AW(4)) dut (
      .clk         (clk),
      .reset_all_n (reset_all_n),
      .bus         (bus.slave)
   );

   always #5 clk = ~clk;

   // Edge counter used to check write-back spacing.
   always @(posedge clk) cyc <= cyc + 1;

   // Write-port monitor and bank model, sampled mid-cycle.
   always @(negedge clk) begin
      if (bus.wb_write !== bus.wb_enable) en_bad++;
      if (bus.wb_write === 1'b1) begin
         wr_rd.push_back(bus.wb_rd);
         wr_data.push_back(bus.wb_data);
         wr_cyc.push_back(cyc);
         bank[bus.wb_rd] = bus.wb_data;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clear_log();
      wr_rd.delete();
      wr_data.delete();
      wr_cyc.delete();
      en_bad = 0;
   endtask

   // Issue one operation (start sampled at edge 0); optionally pulse a
   // competing 50/5 start after edge inj. Returns the edge at which done
   // was seen, or -1 if it never came within the budget.
   task automatic run_op(input logic [31:0] dvd, input logic [31:0] dvs,
                         input logic [3:0] rq, input logic [3:0] rr,
                         input int inj, output int l);
      clear_log();
      bus.dividend = dvd;
      bus.divisor  = dvs;
      bus.rd_q     = rq;
      bus.rd_r     = rr;
      bus.start    = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      l = -1;
      for (int k = 1; k <= 60; k++) begin
         @(posedge clk); #1;
         if (inj != 0 && k == inj) begin
            bus.dividend = 32'd50;
            bus.divisor  = 32'd5;
            bus.start    = 1'b1;
         end else begin
            bus.start = 1'b0;
         end
         if (bus.done === 1'b1) begin
            l = k;
            break;
         end
      end
      bus.start = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 16; i++) bank[i] = 32'd0;
      bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
      bus.rd_q = '0; bus.rd_r = '0;
`ifdef DIV_SIGNED_EN
      bus.sign_op = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_done", {31'd0, bus.done}, 32'd0);
      chk("rst_dz", {31'd0, bus.div_zero}, 32'd0);
      chk("rst_wr", {30'd0, bus.wb_write, bus.wb_enable}, 32'd0);
      chk("rst_q", bus.quotient, 32'd0);
      chk("rst_r", bus.remainder, 32'd0);
      chk("rst_wbd", bus.wb_data, 32'd0);
      chk("rst_wbrd", {28'd0, bus.wb_rd}, 32'd0);
      @(negedge clk); reset_all_n = 1'b1;
      @(posedge clk); #1;

      // 100 / 7 into R4/R5
      run_op(32'd100, 32'd7, 4'd4, 4'd5, 0, lat);
      chk("lat_100_7", lat, 32'd35);
      chk("q_100_7", bus.quotient, 32'd14);
      chk("r_100_7", bus.remainder, 32'd2);
      chk("dz_100_7", {31'd0, bus.div_zero}, 32'd0);
      chk("nwr_100_7", wr_rd.size(), 32'd2);
      if (wr_rd.size() == 2) begin
         chk("wr0_rd", {28'd0, wr_rd[0]}, 32'd4);
         chk("wr0_data", wr_data[0], 32'd14);
         chk("wr1_rd", {28'd0, wr_rd[1]}, 32'd5);
         chk("wr1_data", wr_data[1], 32'd2);
         chk("wr_gap", wr_cyc[1] - wr_cyc[0], 32'd1);
      end
      chk("en_pair", en_bad, 32'd0);
      @(posedge clk); #1;
      chk("done_pulse", {31'd0, bus.done}, 32'd0);
      chk("idle_busy", {31'd0, bus.busy}, 32'd0);

      // All-ones / 1, then 5 / 9
      run_op(32'hFFFF_FFFF, 32'd1, 4'd1, 4'd2, 0, lat);
      chk("q_max_1", bus.quotient, 32'hFFFF_FFFF);
      chk("r_max_1", bus.remainder, 32'd0);
      run_op(32'd5, 32'd9, 4'd1, 4'd2, 0, lat);
      chk("q_5_9", bus.quotient, 32'd0);
      chk("r_5_9", bus.remainder, 32'd5);
      chk("bank_5_9", bank[2], 32'd5);

      // Divide by zero
      run_op(32'h1234, 32'd0, 4'd6, 4'd7, 0, lat);
      chk("lat_dz", lat, 32'd3);
      chk("dz_flag", {31'd0, bus.div_zero}, 32'd1);
      chk("q_dz", bus.quotient, 32'hFFFF_FFFF);
      chk("r_dz", bus.remainder, 32'h1234);
      chk("bank6_dz", bank[6], 32'hFFFF_FFFF);
      chk("bank7_dz", bank[7], 32'h1234);
      chk("nwr_dz", wr_rd.size(), 32'd2);

      // Start while busy is ignored
      run_op(32'd100, 32'd7, 4'd8, 4'd9, 10, lat);
      chk("lat_inj", lat, 32'd35);
      chk("q_inj", bus.quotient, 32'd14);
      chk("r_inj", bus.remainder, 32'd2);
      chk("nwr_inj", wr_rd.size(), 32'd2);
      chk("dz_clear", {31'd0, bus.div_zero}, 32'd0);

      // Same destination for both results; register 0 as destination
      run_op(32'd17, 32'd5, 4'd3, 4'd3, 0, lat);
      chk("bank3_same", bank[3], 32'd2);
      chk("nwr_same", wr_rd.size(), 32'd2);
      run_op(32'd10, 32'd3, 4'd0, 4'd1, 0, lat);
      chk("bank0", bank[0], 32'd3);
      chk("bank1", bank[1], 32'd1);

      // Asynchronous reset in the middle of CALC
      bus.dividend = 32'd100; bus.divisor = 32'd7;
      bus.rd_q = 4'd10; bus.rd_r = 4'd11;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      clear_log();
      reset_all_n = 1'b0;
      #1;
      chk("mid_busy", {31'd0, bus.busy}, 32'd0);
      chk("mid_wr", {30'd0, bus.wb_write, bus.wb_enable}, 32'd0);
      chk("mid_q", bus.quotient, 32'd0);
      chk("mid_r", bus.remainder, 32'd0);
      repeat (2) @(negedge clk);
      reset_all_n = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      chk("post_rst_nwr", wr_rd.size(), 32'd0);
      chk("post_rst_busy", {31'd0, bus.busy}, 32'd0);
      run_op(32'd100, 32'd7, 4'd12, 4'd13, 0, lat);
      chk("lat_after_rst", lat, 32'd35);
      chk("q_after_rst", bus.quotient, 32'd14);
      chk("r_after_rst", bus.remainder, 32'd2);

`ifdef DIV_SIGNED_EN
      // -7 / 2 truncates toward zero: -3 remainder -1
      bus.sign_op = 1'b1;
      run_op(32'hFFFF_FFF9, 32'd2, 4'd1, 4'd2, 0, lat);
      chk("lat_s", lat, 32'd35);
      chk("q_s_m7_2", bus.quotient, 32'hFFFF_FFFD);
      chk("r_s_m7_2", bus.remainder, 32'hFFFF_FFFF);
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 4'd1, 4'd2, 0, lat);
      chk("q_s_min", bus.quotient, 32'h8000_0000);
      chk("r_s_min", bus.remainder, 32'd0);
      bus.sign_op = 1'b0;
`endif

      chk("en_final", en_bad, 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
